// File: rtl/jogo_pkg.sv
// Shared definitions for the tic-tac-toe "whose turn" display.
// Holds the active-low 7-segment patterns, the digit table for
// player IDs 1..9 and the display FSM state encoding.
package jogo_pkg;

    // Active-low segment patterns, bit i = segment i (0 top, 6 middle)
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;
    localparam logic [6:0] SEG_E       = 7'b0000110;

    typedef enum logic [1:0] {
        MOSTRA  = 2'd0,
        ERRO    = 2'd1,
        VITORIA = 2'd2
    } estado_t;

    // Digit table for valid player IDs; anything outside 1..9 shows "E"
    function automatic logic [6:0] seg_digito(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decodifica_jogador.sv
// Combinational player-ID to 7-segment decoder.
// Ports:
//   jog  in  W_JOG  player ID (0 = none, 1..MAX_JOG = player, else invalid)
//   seg  out 7      active-low segment pattern
module decodifica_jogador #(
    parameter int W_JOG   = 2,
    parameter int MAX_JOG = 2
) (
    input  logic [W_JOG-1:0] jog,
    output logic [6:0]       seg
);
    import jogo_pkg::*;

    always_comb begin
        seg = SEG_E;
        if (jog == '0) begin
            seg = SEG_TRACO;
        end else if (32'(jog) <= MAX_JOG) begin
            // MAX_JOG never exceeds 9, so the ID fits the 4-bit table index
            seg = seg_digito(4'(jog));
        end
    end

endmodule

// File: rtl/display_jogador_animado.sv
// Registered 7-segment driver for the "whose turn" display.
// Shows the latched player, a timed "E" after an error pulse, and a
// blinking winner until the next turn update.
// Ports:
//   clock     in   1      system clock (rising edge)
//   reset     in   1      synchronous, active-high
//   jogador   in   W_JOG  player ID, sampled only on atualiza/vencedor
//   atualiza  in   1      pulse: latch jogador
//   erro      in   1      pulse: show "E" for ERRO_CICLOS cycles
//   vencedor  in   1      pulse: latch jogador as winner and blink it
//   pisca_en  in   1      level: blink the turn digit while showing it
//   display   out  7      active-low segments
//   ocupado   out  1      high while the error indication is active
module display_jogador_animado #(
    parameter int W_JOG        = 2,
    parameter int MAX_JOG      = 2,
    parameter int PISCA_CICLOS = 25000000,
    parameter int ERRO_CICLOS  = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W_JOG-1:0] jogador,
    input  logic             atualiza,
    input  logic             erro,
    input  logic             vencedor,
    input  logic             pisca_en,
    output logic [6:0]       display,
    output logic             ocupado
);
    import jogo_pkg::*;

    localparam int WP = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
    localparam int WE = (ERRO_CICLOS > 1) ? $clog2(ERRO_CICLOS) : 1;
    localparam logic [WP-1:0] PISCA_FIM = WP'(PISCA_CICLOS - 1);
    localparam logic [WE-1:0] ERRO_FIM  = WE'(ERRO_CICLOS - 1);

    estado_t          state_reg;
    logic [W_JOG-1:0] jog_reg;
    logic             fase_reg;
    logic [WP-1:0]    pisca_cnt_reg;
    logic [WE-1:0]    erro_cnt_reg;
    logic [6:0]       display_reg;
    logic             ocupado_reg;
    logic [6:0]       padrao;

    decodifica_jogador #(
        .W_JOG   (W_JOG),
        .MAX_JOG (MAX_JOG)
    ) u_decod (
        .jog (jog_reg),
        .seg (padrao)
    );

    // The output register is driven from the current state registers, so
    // an event sampled on one edge becomes visible on the following edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= MOSTRA;
            jog_reg       <= '0;
            fase_reg      <= 1'b1;
            pisca_cnt_reg <= '0;
            erro_cnt_reg  <= '0;
            display_reg   <= SEG_TRACO;
            ocupado_reg   <= 1'b0;
        end else begin
            // Free-running blink timebase, independent of the FSM state
            if (pisca_cnt_reg == PISCA_FIM) begin
                pisca_cnt_reg <= '0;
                fase_reg      <= ~fase_reg;
            end else begin
                pisca_cnt_reg <= pisca_cnt_reg + WP'(1);
            end

            case (state_reg)
                MOSTRA: begin
                    display_reg <= (pisca_en && !fase_reg) ? SEG_APAGADO : padrao;
                    ocupado_reg <= 1'b0;
                    if (erro) begin
                        state_reg    <= ERRO;
                        erro_cnt_reg <= '0;
                        if (atualiza) jog_reg <= jogador;
                    end else if (vencedor) begin
                        state_reg <= VITORIA;
                        jog_reg   <= jogador;
                    end else if (atualiza) begin
                        jog_reg <= jogador;
                    end
                end

                ERRO: begin
                    display_reg <= SEG_E;
                    ocupado_reg <= 1'b1;
                    if (erro) begin
                        // A repeated error extends the hold from scratch
                        erro_cnt_reg <= '0;
                        if (atualiza) jog_reg <= jogador;
                    end else if (vencedor) begin
                        // A win takes over the display immediately
                        state_reg    <= VITORIA;
                        jog_reg      <= jogador;
                        erro_cnt_reg <= '0;
                    end else begin
                        if (atualiza) jog_reg <= jogador;
                        if (erro_cnt_reg == ERRO_FIM) begin
                            state_reg    <= MOSTRA;
                            erro_cnt_reg <= '0;
                        end else begin
                            erro_cnt_reg <= erro_cnt_reg + WE'(1);
                        end
                    end
                end

                VITORIA: begin
                    // Winner always blinks, whatever pisca_en says
                    display_reg <= fase_reg ? padrao : SEG_APAGADO;
                    ocupado_reg <= 1'b0;
                    if (atualiza) begin
                        state_reg <= MOSTRA;
                        jog_reg   <= jogador;
                    end
                end

                default: begin
                    state_reg   <= MOSTRA;
                    display_reg <= SEG_TRACO;
                    ocupado_reg <= 1'b0;
                end
            endcase
        end
    end

    assign display = display_reg;
    assign ocupado = ocupado_reg;

endmodule

// File: tb/tb_display_jogador_animado.sv
// Bench for display_jogador_animado with short blink/error periods.
// Directed vector table, multi-cycle error-hold sequences and a random
// run checked against a cycle-level reference model.
module tb_display_jogador_animado;

    localparam int P  = 4;
    localparam int EC = 6;
    localparam int WJ = 4;
    localparam int MJ = 3;

    localparam logic [6:0] D_TRACO = 7'b0111111;
    localparam logic [6:0] D_E     = 7'b0000110;
    localparam logic [6:0] D_BLANK = 7'b1111111;
    localparam logic [6:0] D_1     = 7'b1111001;
    localparam logic [6:0] D_2     = 7'b0100100;
    localparam logic [6:0] D_3     = 7'b0110000;

    logic          clock = 1'b0;
    logic          reset, atualiza, erro, vencedor, pisca_en;
    logic [WJ-1:0] jogador;
    logic [6:0]    display;
    logic          ocupado;

    int total = 0;
    int bad   = 0;

    display_jogador_animado #(
        .W_JOG        (WJ),
        .MAX_JOG      (MJ),
        .PISCA_CICLOS (P),
        .ERRO_CICLOS  (EC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .jogador  (jogador),
        .atualiza (atualiza),
        .erro     (erro),
        .vencedor (vencedor),
        .pisca_en (pisca_en),
        .display  (display),
        .ocupado  (ocupado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // mode: 0 showing turn, 1 error hold, 2 winner
    logic [6:0] dig_tab [10];
    int         m_mode = 0;
    int         m_jog  = 0;
    int         m_rest = 0;   // cycles of error hold still to go
    int         m_k    = 0;   // edges since reset released
    logic [6:0] m_disp = D_TRACO;
    logic       m_oc   = 1'b0;

    function automatic logic [6:0] ref_decode(input int v);
        if (v == 0) return D_TRACO;
        if (v <= MJ) return dig_tab[v];
        return D_E;
    endfunction

    task automatic model_edge(input logic r, input int j, input logic a, input logic e,
                              input logic v, input logic p);
        logic vis;
        if (r) begin
            m_mode = 0; m_jog = 0; m_rest = 0; m_k = 0;
            m_disp = D_TRACO; m_oc = 1'b0;
        end else begin
            vis = ((m_k / P) % 2) == 0;
            case (m_mode)
                0:       m_disp = (p && !vis) ? D_BLANK : ref_decode(m_jog);
                1:       m_disp = D_E;
                default: m_disp = vis ? ref_decode(m_jog) : D_BLANK;
            endcase
            m_oc = (m_mode == 1);
            m_k++;
            case (m_mode)
                0: begin
                    if (e) begin
                        m_mode = 1; m_rest = EC;
                        if (a) m_jog = j;
                    end else if (v) begin
                        m_mode = 2; m_jog = j;
                    end else if (a) m_jog = j;
                end
                1: begin
                    if (e) begin
                        m_rest = EC;
                        if (a) m_jog = j;
                    end else if (v) begin
                        m_mode = 2; m_jog = j;
                    end else begin
                        if (a) m_jog = j;
                        m_rest--;
                        if (m_rest == 0) m_mode = 0;
                    end
                end
                default: begin
                    if (a) begin
                        m_mode = 0; m_jog = j;
                    end
                end
            endcase
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] j, input logic a, input logic e,
                        input logic v, input logic p);
        reset = r; jogador = j; atualiza = a; erro = e; vencedor = v; pisca_en = p;
        @(posedge clock);
        model_edge(r, int'(j), a, e, v, p);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] j;
        logic       a, e, v, p;
        logic [6:0] d;
        logic       o;
    } vec_t;

    vec_t tab [21];

    function automatic vec_t mk(input logic r, input logic [3:0] j, input logic a,
                                input logic e, input logic v, input logic p,
                                input logic [6:0] d, input logic o);
        vec_t t;
        t.r = r; t.j = j; t.a = a; t.e = e; t.v = v; t.p = p; t.d = d; t.o = o;
        return t;
    endfunction

    int n_e, n_o;

    initial begin
        dig_tab[0] = D_TRACO;   dig_tab[1] = D_1;         dig_tab[2] = D_2;
        dig_tab[3] = D_3;       dig_tab[4] = 7'b0011001;  dig_tab[5] = 7'b0010010;
        dig_tab[6] = 7'b0000010; dig_tab[7] = 7'b1111000; dig_tab[8] = 7'b0000000;
        dig_tab[9] = 7'b0010000;

        reset = 1'b1; jogador = '0; atualiza = 0; erro = 0; vencedor = 0; pisca_en = 0;

        // ---- directed table: one entry per clock edge ----
        //             r  j  a  e  v  p  display  oc
        tab[0]  = mk(1, 0, 0, 0, 0, 0, D_TRACO, 0);
        tab[1]  = mk(1, 0, 0, 0, 0, 0, D_TRACO, 0);
        tab[2]  = mk(0, 0, 0, 0, 0, 0, D_TRACO, 0);
        tab[3]  = mk(0, 2, 1, 0, 0, 0, D_TRACO, 0);
        tab[4]  = mk(0, 9, 0, 0, 0, 0, D_2,     0);   // jogador ignored w/o pulse
        tab[5]  = mk(0, 0, 0, 0, 0, 0, D_2,     0);
        tab[6]  = mk(0, 0, 0, 1, 0, 0, D_2,     0);
        tab[7]  = mk(0, 0, 0, 0, 0, 0, D_E,     1);
        tab[8]  = mk(0, 1, 1, 0, 0, 0, D_E,     1);
        tab[9]  = mk(0, 3, 0, 0, 1, 0, D_E,     1);   // win overrides error
        tab[10] = mk(0, 0, 0, 0, 0, 0, D_3,     0);   // edge k=8, visible phase
        tab[11] = mk(0, 0, 0, 0, 0, 0, D_3,     0);
        tab[12] = mk(0, 0, 0, 1, 0, 0, D_3,     0);   // erro ignored in win
        tab[13] = mk(0, 0, 0, 0, 0, 0, D_3,     0);
        tab[14] = mk(0, 0, 0, 0, 0, 0, D_BLANK, 0);   // k=12, blank phase
        tab[15] = mk(0, 1, 1, 0, 0, 0, D_BLANK, 0);
        tab[16] = mk(0, 0, 0, 0, 0, 0, D_1,     0);
        tab[17] = mk(0, 5, 1, 0, 0, 0, D_1,     0);
        tab[18] = mk(0, 0, 0, 0, 0, 0, D_E,     0);   // invalid ID shows E
        tab[19] = mk(0, 0, 1, 0, 0, 0, D_E,     0);
        tab[20] = mk(0, 0, 0, 0, 0, 0, D_TRACO, 0);

        for (int i = 0; i < 21; i++) begin
            step(tab[i].r, tab[i].j, tab[i].a, tab[i].e, tab[i].v, tab[i].p);
            check($sformatf("vec%0d_display", i), display, tab[i].d);
            check($sformatf("vec%0d_ocupado", i), {6'b0, ocupado}, {6'b0, tab[i].o});
        end

        // ---- single error pulse: exactly EC cycles of E ----
        step(1, 0, 0, 0, 0, 0);
        step(0, 2, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        n_e = 0; n_o = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (display == D_E) n_e++;
            if (ocupado) n_o++;
        end
        check("erro_hold_e_cycles", 7'(n_e), 7'(EC));
        check("erro_hold_ocupado_cycles", 7'(n_o), 7'(EC));
        check("erro_hold_return", display, D_2);

        // ---- second erro on the 3rd cycle extends the hold to 9 ----
        step(0, 0, 0, 1, 0, 0);
        n_e = 0; n_o = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, (i == 3), 0, 0);
            if (display == D_E) n_e++;
            if (ocupado) n_o++;
        end
        check("erro_extend_e_cycles", 7'(n_e), 7'd9);
        check("erro_extend_ocupado_cycles", 7'(n_o), 7'd9);

        // ---- reset in the middle of a win ----
        step(0, 3, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("reset_mid_win_display", display, D_TRACO);
        check("reset_mid_win_ocupado", {6'b0, ocupado}, 7'd0);

        // ---- turn blinking with pisca_en, checked by the model ----
        step(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0, 1);
            check($sformatf("blink%0d", i), display, m_disp);
        end

        // ---- random run against the reference model ----
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)));
            check($sformatf("rand%0d_display", i), display, m_disp);
            check($sformatf("rand%0d_ocupado", i), {6'b0, ocupado}, {6'b0, m_oc});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
